// File: rtl/poly1305_pkg.sv
// Shared constants and reduce-FSM state encoding for the Poly1305 mod 2^130-5 reducer.
package poly1305_pkg;

    localparam int PROD_W = 258;
    localparam int RES_W  = 130;
    localparam int P_C    = 5;

    localparam logic [RES_W-1:0] P1305 = 130'h3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD1 = 2'd1,
        FOLD2 = 2'd2,
        FINAL = 2'd3
    } reduce_state_e;

endpackage

// File: rtl/poly1305_fold.sv
// Combinational fold step: o_sum = i_lo + 5*i_hi, using 2^130 == 5 (mod p).
module poly1305_fold #(
    parameter int LO_W  = 130,
    parameter int HI_W  = 128,
    parameter int SUM_W = 132
) (
    input  logic [LO_W-1:0]  i_lo,
    input  logic [HI_W-1:0]  i_hi,
    output logic [SUM_W-1:0] o_sum
);

    logic [SUM_W-1:0] w_hi_ext;

    // 5*hi as (hi<<2)+hi keeps this a pair of adders rather than a multiplier.
    assign w_hi_ext = SUM_W'(i_hi);
    assign o_sum    = SUM_W'(i_lo) + (w_hi_ext << 2) + w_hi_ext;

endmodule

// File: rtl/poly1305_reduce_p130.sv
// Reduces a 258-bit product modulo 2^130-5 in four cycles (IDLE, FOLD1, FOLD2, FINAL).
// Define POLY1305_REDUCE_CANON_EN for a canonical result in [0, p); otherwise it is partial.
module poly1305_reduce_p130
    import poly1305_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PROD_W-1:0] prod_in,
    output logic [RES_W-1:0]  result_out,
    output logic              busy,
    output logic              done
);

    reduce_state_e      r_state;
    logic [PROD_W-1:0]  r_prod;
    logic [RES_W+1:0]   r_s1;
    logic [RES_W:0]     r_s2;
    logic [RES_W-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    logic [RES_W+1:0]   w_s1;
    logic [RES_W:0]     w_s2;
    logic [RES_W-1:0]   w_res;

    poly1305_fold #(
        .LO_W  (RES_W),
        .HI_W  (PROD_W - RES_W),
        .SUM_W (RES_W + 2)
    ) u_fold1 (
        .i_lo  (r_prod[RES_W-1:0]),
        .i_hi  (r_prod[PROD_W-1:RES_W]),
        .o_sum (w_s1)
    );

    // s1 < 2^132, so its top two bits fold into a value no larger than 2^130+14.
    poly1305_fold #(
        .LO_W  (RES_W),
        .HI_W  (2),
        .SUM_W (RES_W + 1)
    ) u_fold2 (
        .i_lo  (r_s1[RES_W-1:0]),
        .i_hi  (r_s1[RES_W+1:RES_W]),
        .o_sum (w_s2)
    );

`ifdef POLY1305_REDUCE_CANON_EN
    // s2 < 2p, so one conditional subtract yields the canonical residue.
    assign w_res = (r_s2 >= {1'b0, P1305}) ? RES_W'(r_s2 - {1'b0, P1305})
                                           : r_s2[RES_W-1:0];
`else
    // With bit 130 set the low bits are at most 14, so adding 5 cannot overflow.
    assign w_res = r_s2[RES_W] ? (r_s2[RES_W-1:0] + RES_W'(P_C))
                               : r_s2[RES_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_prod   <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_prod  <= prod_in;
                        r_busy  <= 1'b1;
                        r_state <= FOLD1;
                    end
                end
                FOLD1: begin
                    r_s1    <= w_s1;
                    r_state <= FOLD2;
                end
                FOLD2: begin
                    r_s2    <= w_s2;
                    r_state <= FINAL;
                end
                FINAL: begin
                    r_result <= w_res;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result_out = r_result;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
